// File: rtl/notepad_pkg.sv
// notepad_pkg: shared glyph geometry, screen constants and draw-sequencer state type.
package notepad_pkg;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
    localparam int COLOUR_W   = 3;
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int COL_W      = $clog2(GLYPH_W);
    localparam int ROW_W      = $clog2(GLYPH_H);
    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} draw_state_t;
endpackage

// File: rtl/glyph_pixel_counter.sv
// glyph_pixel_counter: column/row position within a glyph with clear, enable and last-pixel flag.
module glyph_pixel_counter
    import notepad_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    assign last = (col == COL_W'(GLYPH_W - 1)) && (row == ROW_W'(GLYPH_H - 1));
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            col <= (col == COL_W'(GLYPH_W - 1)) ? '0 : col + 1'b1;
            row <= (col == COL_W'(GLYPH_W - 1)) ? row + 1'b1 : row;
        end
    end
endmodule

// File: rtl/glyph_draw_ctrl.sv
// glyph_draw_ctrl: loads a 128-bit glyph into the external shifter and plots it pixel by pixel.
// Define TRANSPARENT_BG_EN to suppress plots for 0-bits (background left untouched).
module glyph_draw_ctrl
    import notepad_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [GLYPH_BITS-1:0] req_glyph,
    input  logic [X_W-1:0]        req_x,
    input  logic [Y_W-1:0]        req_y,
    input  logic [COLOUR_W-1:0]   req_fg,
    input  logic [COLOUR_W-1:0]   req_bg,
    input  logic                  abort,
    output logic [GLYPH_BITS-1:0] sh_load_val,
    output logic                  sh_load,
    output logic                  sh_shift,
    input  logic                  sh_bit,
    output logic                  plot,
    output logic [X_W-1:0]        plot_x,
    output logic [Y_W-1:0]        plot_y,
    output logic [COLOUR_W-1:0]   plot_colour,
    output logic                  done
);
    draw_state_t          state;
    logic [X_W-1:0]       x0;
    logic [Y_W-1:0]       y0;
    logic [COLOUR_W-1:0]  fg, bg;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic                 last;
    logic                 drawing;

    glyph_pixel_counter u_counter (
        .clock(clock),
        .reset(reset),
        .clear(state == LOAD),
        .en   (drawing),
        .col  (col),
        .row  (row),
        .last (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sh_load_val <= '0;
            x0          <= '0;
            y0          <= '0;
            fg          <= '0;
            bg          <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    state       <= LOAD;
                    sh_load_val <= req_glyph;
                    x0          <= req_x;
                    y0          <= req_y;
                    fg          <= req_fg;
                    bg          <= req_bg;
                end
                LOAD:    state <= abort ? IDLE : DRAW;
                DRAW:    state <= abort ? IDLE : (last ? DONE : DRAW);
                default: state <= IDLE;
            endcase
        end
    end

    assign drawing     = (state == DRAW);
    assign req_ready   = (state == IDLE);
    assign sh_load     = (state == LOAD);
    assign sh_shift    = drawing;
    assign done        = (state == DONE);
    assign plot_x      = drawing ? x0 + X_W'(col) : '0;
    assign plot_y      = drawing ? y0 + Y_W'(row) : '0;
    assign plot_colour = drawing ? (sh_bit ? fg : bg) : '0;
`ifdef TRANSPARENT_BG_EN
    assign plot        = drawing && sh_bit;
`else
    assign plot        = drawing;
`endif
endmodule

// File: tb/tb_glyph_draw_ctrl.sv
// tb_glyph_draw_ctrl: directed checks of the glyph draw sequencer against a behavioural shifter.
module tb_glyph_draw_ctrl;
`ifdef TRANSPARENT_BG_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [127:0] req_glyph = '0;
    logic [7:0]   req_x = '0;
    logic [6:0]   req_y = '0;
    logic [2:0]   req_fg = '0;
    logic [2:0]   req_bg = '0;
    logic         abort = 1'b0;
    logic [127:0] sh_load_val;
    logic         sh_load, sh_shift, sh_bit, plot, done;
    logic [7:0]   plot_x;
    logic [6:0]   plot_y;
    logic [2:0]   plot_colour;
    logic [127:0] shreg = '0;
    int           errors = 0;
    int           checks = 0;

    glyph_draw_ctrl dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_glyph(req_glyph), .req_x(req_x), .req_y(req_y), .req_fg(req_fg), .req_bg(req_bg),
        .abort(abort), .sh_load_val(sh_load_val), .sh_load(sh_load), .sh_shift(sh_shift),
        .sh_bit(sh_bit), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .done(done)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (sh_load) shreg <= sh_load_val;
        else if (sh_shift) shreg <= shreg << 1;
    end
    assign sh_bit = shreg[127];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic draw(input logic [127:0] g, input logic [7:0] x, input logic [6:0] y,
                        input logic [2:0] fg, input logic [2:0] bg, input int stop_at, input bit use_reset);
        int         plots;
        logic       b;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_glyph = g; req_x = x; req_y = y; req_fg = fg; req_bg = bg;
        @(negedge clock);
        req_valid = 1'b0; req_glyph = ~g; req_x = x + 8'd33; req_y = y + 7'd9; req_fg = ~fg; req_bg = ~bg;
        check("load_ctl", {sh_load, sh_shift, plot, req_ready}, 4'b1000);
        check("load_val", sh_load_val, g);
        plots = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clock);
            b  = g[127 - i];
            ex = x + 8'(i % 8);
            ey = y + 7'(i / 8);
            ec = b ? fg : bg;
            check("plot", plot, TRANSP ? b : 1'b1);
            check("shift_ctl", {sh_load, sh_shift, done}, 3'b010);
            check("plot_x", plot_x, ex);
            check("plot_y", plot_y, ey);
            if (plot) begin
                plots++;
                check("colour", plot_colour, ec);
            end
            if (i == stop_at) begin
                if (use_reset) reset = 1'b1; else abort = 1'b1;
                @(negedge clock);
                reset = 1'b0; abort = 1'b0;
                check("stop_ctl", {req_ready, plot, sh_shift, sh_load, done}, 5'b10000);
                check("stop_pix", {plot_x, plot_y, plot_colour}, 0);
                if (use_reset) check("rst_load_val", sh_load_val, 0);
                @(negedge clock);
                check("stop_no_done", {done, req_ready}, 2'b01);
                return;
            end
        end
        check("plot_count", plots, TRANSP ? 128'($countones(g)) : 128'd128);
        @(negedge clock);
        check("done", {done, plot, sh_shift, req_ready}, 4'b1000);
        @(negedge clock);
        check("ready_after", {req_ready, done}, 2'b10);
    endtask

    initial begin
        int idle_bad;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        check("rst_ctl", {req_ready, sh_load, sh_shift, plot, done}, 5'b10000);
        check("rst_pix", {plot_x, plot_y, plot_colour}, 0);
        check("rst_load_val", sh_load_val, 0);
        reset = 1'b0;
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (plot || done || sh_load || sh_shift || !req_ready) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);
        draw({1'b1, 126'b0, 1'b1}, 8'd10, 7'd5, 3'd7, 3'd0, -1, 1'b0);
        draw(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'd250, 7'd120, 3'd5, 3'd2, -1, 1'b0);
        draw({64{2'b10}}, 8'd3, 7'd4, 3'd6, 3'd1, 39, 1'b0);
        draw({64{2'b10}}, 8'd20, 7'd30, 3'd6, 3'd1, -1, 1'b0);
        draw(128'hFFFF_0000_AAAA_5555_1234_8765_0F0F_F0F0, 8'd100, 7'd60, 3'd3, 3'd4, 70, 1'b1);
        draw(128'hC3C3_C3C3_0000_FFFF_8001_8001_7E7E_7E7E, 8'd0, 7'd0, 3'd1, 3'd6, -1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
